// File: rtl/drive_free_pkg.sv
// Shared definitions for the drive/free source bridge and its helpers.
//   state_t                 : bridge FSM state (IDLE, DRIVE, WAIT_FREE), 2-bit encoding
//   DEFAULT_SYNC_STAGES     : default flip-flop depth of the i_free synchroniser
//   DEFAULT_DRIVE_PULSE_CYC : default number of cycles o_drive is held high per token
package drive_free_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DRIVE     = 2'd1,
    ST_WAIT_FREE = 2'd2
  } state_t;

  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DRIVE_PULSE_CYC = 1;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser followed by a rising-edge detector.
// Brings an asynchronous level into the clk domain and produces a one-cycle
// pulse for each low-to-high transition seen at the synchroniser output.
// Ports:
//   clk      : sole clock, rising edge
//   rst      : synchronous active-high reset, clears the chain and edge register
//   async_in : asynchronous input level
//   rise     : one-cycle pulse on a rising edge of the synchronised level
module sync_edge_det
  import drive_free_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign rise = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/drive_free_src_bridge.sv
// Synchronous-to-asynchronous source stage for one input port of the mutex
// merge. Words arrive over valid/ready, are buffered in a small FIFO and issued
// one at a time as a drive pulse; the data is held until the returning free
// pulse has been synchronised and detected. One token outstanding at a time.
// Optional build macro: DRIVE_FREE_SRC_TIMEOUT_EN enables a sticky watchdog
// on o_timeout (WAIT_FREE longer than TIMEOUT_CYC cycles, or a spurious free).
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   i_valid, o_ready, i_data : upstream valid/ready word interface
//   o_drive   : drive pulse to the merge stage (high while in DRIVE)
//   o_data    : token data, registered, stable while a token is outstanding
//   i_free    : free pulse returned from the merge stage, asynchronous
//   o_busy    : a token is outstanding
//   o_timeout : sticky watchdog flag (0 when the watchdog is compiled out)
module drive_free_src_bridge
  import drive_free_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DRIVE_PULSE_CYC = DEFAULT_DRIVE_PULSE_CYC,
  parameter int TIMEOUT_CYC     = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_drive,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_free,
  output logic                  o_busy,
  output logic                  o_timeout
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int PULSE_W = (DRIVE_PULSE_CYC > 1) ? $clog2(DRIVE_PULSE_CYC) : 1;

  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [PULSE_W-1:0]    pulse_cnt_reg;
  state_t                state_reg, state_next;

  logic free_evt;
  logic push, pop, load;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_free_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (i_free),
    .rise     (free_evt)
  );

  // Ready depends only on the registered count, so there is no path from i_valid.
  assign o_ready = (count_reg != CNT_W'(FIFO_DEPTH));
  assign push    = i_valid & o_ready;
  // The in-flight word stays at the FIFO head until its free returns.
  assign pop     = (state_reg == ST_WAIT_FREE) & free_evt;
  assign load    = (state_reg == ST_IDLE) & (count_reg != '0);

  // FIFO storage: write port only, no reset so it can map to RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= i_data;
    end
  end

  // Registered read of the head into the output data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg <= '0;
    end else if (load) begin
      data_reg <= fifo_mem[rd_ptr_reg];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      pulse_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_DRIVE && state_next == ST_DRIVE) begin
        pulse_cnt_reg <= pulse_cnt_reg + PULSE_W'(1);
      end else begin
        pulse_cnt_reg <= '0;
      end
    end
  end

  // Free events outside WAIT_FREE are ignored; passing through IDLE between
  // tokens guarantees a low gap on o_drive.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (count_reg != '0) begin
          state_next = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (pulse_cnt_reg == PULSE_W'(DRIVE_PULSE_CYC - 1)) begin
          state_next = ST_WAIT_FREE;
        end
      end
      ST_WAIT_FREE: begin
        if (free_evt) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign o_drive = (state_reg == ST_DRIVE);
  assign o_busy  = (state_reg != ST_IDLE);
  assign o_data  = data_reg;

`ifdef DRIVE_FREE_SRC_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;

  logic [WD_W-1:0] wd_cnt_reg;
  logic            timeout_reg;

  // Counter saturates at TIMEOUT_CYC; the flag is raised on the same edge the
  // counter reaches the limit and is only cleared by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
    end else begin
      if (state_reg == ST_DRIVE && state_next == ST_WAIT_FREE) begin
        wd_cnt_reg <= '0;
      end else if (state_reg == ST_WAIT_FREE && wd_cnt_reg != WD_W'(TIMEOUT_CYC)) begin
        wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
        if (wd_cnt_reg == WD_W'(TIMEOUT_CYC - 1)) begin
          timeout_reg <= 1'b1;
        end
      end
      if (free_evt && state_reg != ST_WAIT_FREE) begin
        timeout_reg <= 1'b1;
      end
    end
  end

  assign o_timeout = timeout_reg;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign o_timeout          = 1'b0;
`endif

endmodule

// File: tb/tb_drive_free_src_bridge.sv
// Self-checking bench for drive_free_src_bridge: a cycle table for the single
// word case, hand-written sequences for backpressure, pointer wrap, spurious
// free, reset mid-token and watchdog, and a scoreboard that checks every drive
// pulse's data against the order words were accepted.
module tb_drive_free_src_bridge;

  localparam int DW = 32;

`ifdef DRIVE_FREE_SRC_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_data;
  logic          o_drive;
  logic [DW-1:0] o_data;
  logic          i_free;
  logic          o_busy;
  logic          o_timeout;

  drive_free_src_bridge #(
    .DATA_WIDTH      (DW),
    .FIFO_DEPTH      (4),
    .SYNC_STAGES     (2),
    .DRIVE_PULSE_CYC (1),
    .TIMEOUT_CYC     (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_data    (i_data),
    .o_drive   (o_drive),
    .o_data    (o_data),
    .i_free    (i_free),
    .o_busy    (o_busy),
    .o_timeout (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            checks   = 0;
  int            failures = 0;
  int            n_drives = 0;
  logic [DW-1:0] sb [$];

  typedef struct {
    logic          valid;
    logic [DW-1:0] data;
    logic          free;
    logic          exp_drive;
    logic          exp_busy;
    logic          exp_ready;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d, output logic ok);
    ok      = 1'b0;
    i_valid = 1'b1;
    i_data  = d;
    for (int n = 0; n < 60 && !ok; n++) begin
      if (o_ready) begin
        sb.push_back(d);
        ok = 1'b1;
      end
      tick();
    end
    i_valid = 1'b0;
  endtask

  task automatic wait_wait_free(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      if (o_busy && !o_drive) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic free_pulse();
    i_free = 1'b1;
    repeat (3) tick();
    i_free = 1'b0;
    repeat (3) tick();
  endtask

  task automatic do_free();
    logic ok;
    wait_wait_free(ok);
    chk("wait_free_reached", ok, 1);
    free_pulse();
  endtask

  // Scoreboard monitor: every rising o_drive pops the oldest accepted word.
  initial begin
    logic          dprev;
    logic          bprev;
    logic [DW-1:0] exp;
    dprev = 1'b0;
    bprev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        dprev = 1'b0;
        bprev = 1'b0;
      end else begin
        if (o_drive && !dprev) begin
          n_drives++;
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow: drive with data 0x%08h but no word expected", o_data);
          end else begin
            exp = sb.pop_front();
            chk("drive_data", o_data, exp);
            $display("token %0d data=0x%08h expected=0x%08h", n_drives, o_data, exp);
          end
          chk("idle_gap", bprev, 0);
        end
        dprev = o_drive;
        bprev = o_busy;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    logic ok;
    int   acc;
    int   base;

    rst = 1'b1; i_valid = 1'b0; i_data = '0; i_free = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_ready", o_ready, 1);
    chk("rst_drive", o_drive, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_data", o_data, 0);
    chk("rst_timeout", o_timeout, 0);
    tick();

    // Single word, cycle by cycle.
    tbl[0] = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
    tbl[1] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA5A5_0001};
    tbl[2] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA5A5_0001};
    tbl[3] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA5A5_0001};
    tbl[4] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA5A5_0001};
    tbl[5] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001};
    tbl[6] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001};
    tbl[7] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001};
    for (int i = 0; i < 8; i++) begin
      i_valid = tbl[i].valid;
      i_data  = tbl[i].data;
      i_free  = tbl[i].free;
      if (tbl[i].valid && o_ready) sb.push_back(tbl[i].data);
      tick();
      chk($sformatf("tbl%0d_drive", i), o_drive, tbl[i].exp_drive);
      chk($sformatf("tbl%0d_busy", i), o_busy, tbl[i].exp_busy);
      chk($sformatf("tbl%0d_ready", i), o_ready, tbl[i].exp_ready);
      chk($sformatf("tbl%0d_data", i), o_data, tbl[i].exp_data);
    end
    i_valid = 1'b0;
    repeat (3) tick();
    chk("single_drives", n_drives, 1);

    // Backpressure: five back-to-back words, only four fit.
    base = n_drives;
    acc  = 0;
    i_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      i_data = 32'hB000_0001 + i;
      if (o_ready) begin
        sb.push_back(i_data);
        acc++;
      end
      tick();
    end
    i_valid = 1'b0;
    chk("bp_accepted", acc, 4);
    chk("bp_ready_full", o_ready, 0);
    repeat (5) tick();
    chk("bp_ready_held", o_ready, 0);
    do_free();
    chk("bp_ready_after_free", o_ready, 1);
    repeat (3) do_free();
    repeat (3) tick();
    chk("bp_drives", n_drives - base, 4);
    chk("bp_sb_empty", sb.size(), 0);
    chk("bp_busy", o_busy, 0);

    // Pointer wrap: ten words with frees running concurrently.
    base = n_drives;
    fork
      begin
        logic pok;
        for (int i = 0; i < 10; i++) begin
          push_word(32'hC000_0000 + i, pok);
          chk("wrap_push", pok, 1);
          repeat ($urandom_range(0, 3)) tick();
        end
      end
      begin
        for (int i = 0; i < 10; i++) do_free();
      end
    join
    repeat (3) tick();
    chk("wrap_drives", n_drives - base, 10);
    chk("wrap_sb_empty", sb.size(), 0);
    chk("wrap_busy", o_busy, 0);

    // Spurious free while idle.
    free_pulse();
    chk("spur_idle_busy", o_busy, 0);
    chk("spur_idle_drive", o_drive, 0);
    chk("spur_idle_timeout", o_timeout, TO_EN);
    repeat (3) tick();

    // Spurious free landing on the DRIVE cycle.
    base = n_drives;
    chk("spur_ready", o_ready, 1);
    i_valid = 1'b1; i_data = 32'hD00D_0001; i_free = 1'b1;
    sb.push_back(i_data);
    tick();
    i_valid = 1'b0;
    tick();
    chk("spur_drive_state", o_drive, 1);
    tick();
    chk("spur_wait_state", {o_busy, o_drive}, 2'b10);
    tick();
    i_free = 1'b0;
    repeat (4) tick();
    chk("spur_no_pop", o_busy, 1);
    chk("spur_drive_timeout", o_timeout, TO_EN);
    do_free();
    chk("spur_done_busy", o_busy, 0);
    chk("spur_drives", n_drives - base, 1);

    // Reset mid-token with two words buffered.
    push_word(32'hE000_0001, ok); chk("rm_push", ok, 1);
    push_word(32'hE000_0002, ok); chk("rm_push", ok, 1);
    push_word(32'hE000_0003, ok); chk("rm_push", ok, 1);
    wait_wait_free(ok);
    chk("rm_wait_free", ok, 1);
    base = n_drives;
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    chk("rm_drive", o_drive, 0);
    chk("rm_busy", o_busy, 0);
    chk("rm_ready", o_ready, 1);
    chk("rm_data", o_data, 0);
    chk("rm_timeout", o_timeout, 0);
    free_pulse();
    repeat (4) tick();
    chk("rm_late_free_busy", o_busy, 0);
    chk("rm_no_drive", n_drives - base, 0);

    // Watchdog: no free for longer than the limit.
    push_word(32'hF000_0001, ok);
    chk("to_push", ok, 1);
    wait_wait_free(ok);
    chk("to_wait_free", ok, 1);
    repeat (15) tick();
    chk("to_before_limit", o_timeout, 0);
    tick();
    chk("to_at_limit", o_timeout, TO_EN);
    repeat (5) tick();
    chk("to_still_busy", o_busy, 1);
    do_free();
    chk("to_done_busy", o_busy, 0);
    chk("to_sticky", o_timeout, TO_EN);
    chk("to_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/drive_free_src_bridge.md
Name: drive_free_src_bridge

Overview:
- Synchronous-to-asynchronous source stage that feeds one input port (drive/free/data triple) of the 3-input mutex merge stage.
- Accepts words from clocked logic over valid/ready, buffers them in a small FIFO, and issues one drive pulse per word.
- Holds the word's data stable until the returning free pulse is synchronised and detected.
- Only one token is outstanding at a time.

Parameters:
- DATA_WIDTH, 32, payload width; matches the merge stage's data width.
- FIFO_DEPTH, 4, buffer entries; power of 2, at least 2.
- SYNC_STAGES, 2, flip-flop stages on i_free; at least 2.
- DRIVE_PULSE_CYC, 1, clock cycles o_drive is held high per token; at least 1.
- TIMEOUT_CYC, 1024, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- i_valid  input  1  upstream word valid.
- o_ready  output  1  FIFO can accept a word.
- i_data  input  DATA_WIDTH  upstream word.
- o_drive  output  1  drive pulse to the merge stage input.
- o_data  output  DATA_WIDTH  token data; registered and stable while a token is outstanding.
- i_free  input  1  free pulse returned from the merge stage; asynchronous to clk.
- o_busy  output  1  a token is outstanding (FSM state is not IDLE).
- o_timeout  output  1  sticky watchdog flag; tied to 0 when the optional feature is compiled out.

Behaviour:
- Reset: one clk and reset only; rst is synchronous and active-high. While rst is high at a clock edge, all of the following clear:
  - FIFO pointers and count go to 0 and o_ready=1.
  - o_drive=0, o_data=0, o_busy=0, o_timeout=0.
  - Sync chain goes to 0 and the FSM goes to IDLE.
- Reset mid-operation discards buffered words and any outstanding token. The merge stage must be reset in the same window.
- Push: i_valid & o_ready at a clock edge writes i_data at the write pointer.
  - o_ready = count != FIFO_DEPTH, from registered count only (no combinational path from i_valid).
- Pop: occurs only on the WAIT_FREE to IDLE transition.
  - Simultaneous push and pop leaves count unchanged.
  - A push into a full FIFO cannot occur, because o_ready=0 when full.
- Pointers are log2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
- Free detection: i_free passes through SYNC_STAGES flip-flops plus one edge register.
  - free_evt = rising edge at the synchroniser output.
  - Environment requirement: i_free high for at least 2 clk periods and low for at least 2 clk periods between pulses.
- FSM states:
  - IDLE: if count != 0, load o_data from the FIFO head and go to DRIVE. Otherwise stay.
  - DRIVE: o_drive=1. A pulse counter runs from 0 to DRIVE_PULSE_CYC-1, then the FSM goes to WAIT_FREE.
  - WAIT_FREE: o_drive=0. On free_evt, pop and go to IDLE.
- o_drive is a Moore output: high exactly when the state is DRIVE.
- At least one IDLE cycle separates consecutive drive pulses, which guarantees a low gap for the click stage.
- Latency, with DRIVE_PULSE_CYC=1 and an empty FIFO:
  - Push at edge N gives o_drive=1 during cycle N+1 to N+2.
  - o_data is valid from the same edge as o_drive.
- o_data is held through DRIVE and WAIT_FREE. It is not cleared in IDLE (holds the last token).
- free_evt in IDLE or DRIVE is spurious and is ignored; state does not change.
- free_evt coinciding with the DRIVE to WAIT_FREE edge is also ignored.

Optional Feature:
- Macro: DRIVE_FREE_SRC_TIMEOUT_EN.
- When defined:
  - A watchdog counter (clog2(TIMEOUT_CYC)+1 bits) clears on entry to WAIT_FREE and increments each cycle in WAIT_FREE.
  - When it reaches TIMEOUT_CYC, o_timeout is set and stays set until rst.
  - The FSM keeps waiting; the token is not dropped or reissued.
  - Spurious free_evt in IDLE or DRIVE also sets o_timeout.
- When undefined: no counter; o_timeout is constant 0.

Decomposition:
- Shared package drive_free_pkg holds:
  - The FSM state typedef (IDLE, DRIVE, WAIT_FREE; 2-bit encoding).
  - Default constants for SYNC_STAGES and DRIVE_PULSE_CYC.
- One natural sub-module: sync_edge_det, the SYNC_STAGES flip-flop synchroniser plus rising-edge register, with clk and rst. It is reusable on the sink side of the merge.
- The FIFO stays inline.

Test Plan:
- Single word, DRIVE_PULSE_CYC=1: push 0xA5A5_0001 at edge 10 -> o_drive high only in cycle 11 with o_data=0xA5A5_0001. Then drive i_free high for 3 cycles starting at cycle 20 -> o_busy falls 3 edges later and count=0.
- Backpressure, FIFO_DEPTH=4: push 5 words back-to-back with no free -> 4 words accepted (one in flight plus 3 buffered, then full), o_ready=0 until the first free_evt. Then return 4 frees -> words 1..4 appear in order, each drive pulse separated by at least one IDLE cycle.
- Pointer wrap: 10 words with frees interleaved and simultaneous push/pop -> all 10 emitted in order, no loss or duplication.
- Spurious free: pulse i_free while IDLE and again during DRIVE -> no state change, no pop. With DRIVE_FREE_SRC_TIMEOUT_EN, o_timeout=1.
- Reset mid-token: rst high one cycle during WAIT_FREE with 2 words buffered -> next edge o_drive=0, o_busy=0, o_ready=1. A later free pulse is ignored.
- Timeout (macro on, TIMEOUT_CYC=16): token with no free -> o_timeout rises 16 cycles after entering WAIT_FREE and stays high after a late free completes the token.
